fetch_queue: RTL



---
 rtl/fetch_queue_if.sv | 47 ++++
 rtl/fetch_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the two buses of the fetch stage:
//     - instruction-memory read port (synchronous, 1-cycle latency)
//     - downstream instruction stream (valid/ready handshake)
//   master : the fetch stage (drives the read strobe/address and the
//            instruction stream, receives read data and ready)
//   slave  : the environment (memory + decode side)
//
//   imem_en     read strobe
//   imem_addr   word address of the read
//   imem_dout   read data, valid the cycle after imem_en
//   inst_valid  head of the prefetch queue is valid
//   inst_ready  downstream accepts the head
//   inst        head instruction word
//   inst_pc     PC of the head instruction
interface fetch_queue_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 14
);
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_dout;
  logic               inst_valid;
  logic               inst_ready;
  logic [XLEN-1:0]    inst;
  logic [XLEN-1:0]    inst_pc;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_dout,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_dout,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch stage: owns the fetch PC, issues reads to a
//   synchronous 1-cycle-latency instruction memory, buffers returned words
//   with their PC in a DEPTH-entry prefetch queue and presents the queue
//   head downstream. Supports zero-bubble redirects and hardware-loop NOP
//   substitution at the head.
//
//   clk                   core clock, all state on rising edge
//   rst_n                 asynchronous active-low reset
//   redirect_valid        load a new fetch PC this cycle
//   redirect_pc           redirect target, bits [1:0] ignored
//   pc_hwl_end_zero_flag  replace the head word by NOP_INST while high
//   bus (master)          imem read port + instruction stream
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 14,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            pc_hwl_end_zero_flag,
  fetch_queue_if.master   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fpc;
  logic [XLEN-1:0]  issue_pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic             inflight_keep;
  logic             issue;
  logic             deq;
  logic             wr_en;
  logic             head_valid;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic [XLEN-1:0]  q_inst [DEPTH];
  logic [XLEN-1:0]  q_pc   [DEPTH];
  logic             unused_pc_bits;

  // Redirect PCs are forced word aligned, so the low two bits never matter.
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Issue decision. Occupancy counts stored words plus the response still
  // on its way, minus the word leaving this cycle; issuing only while that
  // is below DEPTH means every response always finds a free slot. A
  // redirect always issues because it empties the queue.
  always_comb begin
    issue_pc   = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : fpc;
    head_valid = (count != '0);
    deq        = head_valid & bus.inst_ready;
    occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, deq};
    issue      = rst_n & (redirect_valid | (occupancy < (CNT_W+1)'(DEPTH)));
    // The response arriving in a redirect cycle belongs to the old stream.
    wr_en      = inflight & inflight_keep & ~redirect_valid;
  end

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = issue_pc[IMEM_AW+1:2];
  assign bus.inst_valid = head_valid;
  assign bus.inst_pc    = q_pc[rd_ptr];
  assign bus.inst       = pc_hwl_end_zero_flag ? NOP_INST : q_inst[rd_ptr];

  // Fetch PC and in-flight read tracking. The read issued in a redirect
  // cycle is tagged with the redirect target and is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc           <= RESET_PC;
      inflight      <= 1'b0;
      inflight_keep <= 1'b0;
      inflight_pc   <= '0;
    end else begin
      inflight      <= issue;
      inflight_keep <= issue;
      inflight_pc   <= issue_pc;
      if (issue) begin
        fpc <= issue_pc + XLEN'(4);
      end
    end
  end

  // Prefetch queue storage, pointers and count. A redirect flushes the
  // queue; a dequeue in that same cycle has already been taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        q_inst[wr_ptr] <= bus.imem_dout;
        q_pc[wr_ptr]   <= inflight_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(deq);
    end
  end

endmodule
